// File: rtl/vram_dma.sv
// vram_dma: copies a byte block from the CPU-side source port into GPU VRAM,
// writing only while the GPU reports vblank and re-polling it every BURST bytes.
module vram_dma #(
   parameter int VRAM_AW   = 12,
   parameter int BURST     = 32,
   parameter int CLEAR_IRQ = 0
) (
   input  logic               cpu_clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [15:0]        src_i,
   input  logic [VRAM_AW-1:0] dst_i,
   input  logic [12:0]        len_i,
   input  logic [2:0]         sel_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic [15:0]        src_addr_o,
   output logic               src_rd_o,
   input  logic               src_gnt_i,
   input  logic [7:0]         src_data_i,
   output logic [VRAM_AW-1:0] vram_address_o,
   output logic [7:0]         data_o,
   output logic               wen_o,
   input  logic [7:0]         vram_rdata_i,
   output logic               SELECT_pmf_o,
   output logic               SELECT_pmb_o,
   output logic               SELECT_ntbl_o,
   output logic               SELECT_obm_o,
   output logic               SELECT_txbl_o,
   output logic               SELECT_in_vblank_o,
   output logic               SELECT_clr_vblank_irq_o
);
   localparam int            BW       = $clog2(BURST) + 1;
   localparam logic [BW-1:0] BURST_LD = BW'(BURST);
   localparam int            NREG     = 5;

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_READ, S_WAIT, S_WRITE, S_CLR, S_DONE
   } state_t;

   state_t             r_state, w_state_next;
   logic [15:0]        r_src, w_src_next;
   logic [VRAM_AW-1:0] r_dst, w_dst_next;
   logic [12:0]        r_rem, w_rem_next, w_rem_dec;
   logic [BW-1:0]      r_burst, w_burst_next, w_burst_dec;
   logic [2:0]         r_sel, w_sel_next;
   logic               w_err_next;
   logic [NREG-1:0]    w_region;

   // Registered outputs and their next values
   logic               r_busy, w_busy_next;
   logic               r_done, w_done_next;
   logic               r_err, w_err_out_next;
   logic [15:0]        r_src_addr, w_src_addr_next;
   logic               r_src_rd, w_src_rd_next;
   logic [VRAM_AW-1:0] r_vaddr, w_vaddr_next;
   logic [7:0]         r_data, w_data_next;
   logic               r_wen, w_wen_next;
   logic [NREG-1:0]    r_region, w_region_next;
   logic               r_vblank, w_vblank_next;
   logic               r_clr, w_clr_next;

   // Only bit 0 of the VRAM read data carries the in-vblank status
   logic               w_unused;
   assign w_unused = ^vram_rdata_i[7:1];

   for (genvar gi = 0; gi < NREG; gi++) begin : g_region
      assign w_region[gi] = (r_sel == 3'(gi));
   end

   always_comb begin
      w_state_next = r_state;
      w_src_next   = r_src;
      w_dst_next   = r_dst;
      w_rem_next   = r_rem;
      w_burst_next = r_burst;
      w_sel_next   = r_sel;
      w_err_next   = 1'b0;
      w_rem_dec    = r_rem - 13'd1;
      w_burst_dec  = r_burst - BW'(1);
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_src_next   = src_i;
               w_dst_next   = dst_i;
               w_sel_next   = sel_i;
               w_rem_next   = len_i;
               w_burst_next = BURST_LD;
               if (sel_i > 3'd4) begin
                  w_err_next   = 1'b1;
                  w_state_next = S_DONE;
               end else if (len_i == 13'd0) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_POLL;
               end
            end
         end
         S_POLL: begin
            if (vram_rdata_i[0]) w_state_next = S_READ;
         end
         S_READ: begin
            if (src_gnt_i) w_state_next = S_WAIT;
         end
         S_WAIT: w_state_next = S_WRITE;
         S_WRITE: begin
            w_src_next   = r_src + 16'd1;
            w_dst_next   = r_dst + VRAM_AW'(1);
            w_rem_next   = w_rem_dec;
            w_burst_next = w_burst_dec;
            if (w_rem_dec == 13'd0) begin
               w_state_next = (CLEAR_IRQ != 0) ? S_CLR : S_DONE;
            end else if (w_burst_dec == '0) begin
               w_burst_next = BURST_LD;
               w_state_next = S_POLL;
            end else begin
               w_state_next = S_READ;
            end
         end
         S_CLR:   w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (abort_i && (r_state != S_IDLE)) w_state_next = S_IDLE;
   end

   // Outputs are decoded from the upcoming state so they are registered yet
   // line up with the state they belong to.
   always_comb begin
      w_busy_next     = (w_state_next != S_IDLE);
      w_done_next     = 1'b0;
      w_err_out_next  = 1'b0;
      w_src_addr_next = '0;
      w_src_rd_next   = 1'b0;
      w_vaddr_next    = '0;
      w_data_next     = '0;
      w_wen_next      = 1'b0;
      w_region_next   = '0;
      w_vblank_next   = 1'b0;
      w_clr_next      = 1'b0;
      case (w_state_next)
         S_POLL: w_vblank_next = 1'b1;
         S_READ: begin
            w_src_rd_next   = 1'b1;
            w_src_addr_next = w_src_next;
         end
         S_WRITE: begin
            w_wen_next    = 1'b1;
            w_vaddr_next  = w_dst_next;
            w_data_next   = src_data_i;
            w_region_next = w_region;
         end
         S_CLR: begin
            w_wen_next = 1'b1;
            w_clr_next = 1'b1;
         end
         S_DONE: begin
            w_done_next    = 1'b1;
            w_err_out_next = w_err_next;
         end
         default: ;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_src      <= '0;
         r_dst      <= '0;
         r_rem      <= '0;
         r_burst    <= '0;
         r_sel      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_src_addr <= '0;
         r_src_rd   <= 1'b0;
         r_vaddr    <= '0;
         r_data     <= '0;
         r_wen      <= 1'b0;
         r_region   <= '0;
         r_vblank   <= 1'b0;
         r_clr      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_src      <= w_src_next;
         r_dst      <= w_dst_next;
         r_rem      <= w_rem_next;
         r_burst    <= w_burst_next;
         r_sel      <= w_sel_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_err      <= w_err_out_next;
         r_src_addr <= w_src_addr_next;
         r_src_rd   <= w_src_rd_next;
         r_vaddr    <= w_vaddr_next;
         r_data     <= w_data_next;
         r_wen      <= w_wen_next;
         r_region   <= w_region_next;
         r_vblank   <= w_vblank_next;
         r_clr      <= w_clr_next;
      end
   end

   assign busy_o                  = r_busy;
   assign done_o                  = r_done;
   assign err_o                   = r_err;
   assign src_addr_o              = r_src_addr;
   assign src_rd_o                = r_src_rd;
   assign vram_address_o          = r_vaddr;
   assign data_o                  = r_data;
   assign wen_o                   = r_wen;
   assign SELECT_pmf_o            = r_region[0];
   assign SELECT_pmb_o            = r_region[1];
   assign SELECT_ntbl_o           = r_region[2];
   assign SELECT_obm_o            = r_region[3];
   assign SELECT_txbl_o           = r_region[4];
   assign SELECT_in_vblank_o      = r_vblank;
   assign SELECT_clr_vblank_irq_o = r_clr;
endmodule

// File: tb/tb_vram_dma.sv
// Bench for vram_dma: two instances (BURST=32 plain, BURST=2 with IRQ clear)
// share stimulus; a transfer-level model predicts writes, polls and latency.
`timescale 1ns/1ps
module tb_vram_dma;
   localparam int AW          = 12;
   localparam int MAXW        = 4200;
   localparam int BURST_K [2] = '{32, 2};
   localparam int CLR_K   [2] = '{0, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, gnt, vblank;
   logic        abort [2];
   logic [15:0] src_in;
   logic [11:0] dst_in;
   logic [12:0] len_in;
   logic [2:0]  sel_in;
   logic [7:0]  src_data [2];
   wire  [7:0]  vram_rdata = {7'b0, vblank};

   wire         busy [2], done [2], err [2], src_rd [2], wen [2];
   wire  [15:0] src_addr [2];
   wire  [11:0] vaddr [2];
   wire  [7:0]  wdata [2];
   wire  [6:0]  selv [2];   // {clr, in_vblank, txbl, obm, ntbl, pmb, pmf}

   logic [7:0]  mem [65536];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      vram_dma #(.VRAM_AW(AW), .BURST(BURST_K[gi]), .CLEAR_IRQ(CLR_K[gi])) u_dut (
         .cpu_clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort[gi]),
         .src_i(src_in), .dst_i(dst_in), .len_i(len_in), .sel_i(sel_in),
         .busy_o(busy[gi]), .done_o(done[gi]), .err_o(err[gi]),
         .src_addr_o(src_addr[gi]), .src_rd_o(src_rd[gi]), .src_gnt_i(gnt),
         .src_data_i(src_data[gi]), .vram_address_o(vaddr[gi]), .data_o(wdata[gi]),
         .wen_o(wen[gi]), .vram_rdata_i(vram_rdata),
         .SELECT_pmf_o(selv[gi][0]), .SELECT_pmb_o(selv[gi][1]),
         .SELECT_ntbl_o(selv[gi][2]), .SELECT_obm_o(selv[gi][3]),
         .SELECT_txbl_o(selv[gi][4]), .SELECT_in_vblank_o(selv[gi][5]),
         .SELECT_clr_vblank_irq_o(selv[gi][6])
      );
   end

   // Source memory: data arrives the cycle after an accepted read, noise otherwise
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         src_data[k] <= (src_rd[k] && gnt) ? mem[src_addr[k]] : 8'($urandom);
   end

   int errors = 0, checks = 0, edge_n = 0;
   int nwr [2], ndone [2], done_edge [2], nerr [2], nerr_alone [2], npoll [2];
   int nstall [2], nbad [2], nunst [2], nreads [2];
   bit aborted [2];
   int wr_addr [2][MAXW], wr_data [2][MAXW], wr_sel [2][MAXW], wr_edge [2][MAXW];
   logic        p_rd [2], p_ab [2];
   logic [15:0] p_addr [2];
   logic        p_gnt, p_ok;
   int cur_pct, cur_vb, cur_e0, stall_left;
   bit cur_abort;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         p_rd[k]   = src_rd[k];
         p_addr[k] = src_addr[k];
         p_ab[k]   = abort[k];
         if (src_rd[k] && !gnt && rst_n && !abort[k]) nstall[k]++;
      end
      p_gnt = gnt;
      p_ok  = rst_n;
      @(posedge clk);
      edge_n++;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (p_rd[k] && p_gnt && p_ok) nreads[k]++;
         if (p_rd[k] && !p_gnt && p_ok && !p_ab[k] && (!src_rd[k] || src_addr[k] != p_addr[k]))
            nunst[k]++;
         if (wen[k]) begin
            if (nwr[k] < MAXW) begin
               wr_addr[k][nwr[k]] = int'(vaddr[k]);
               wr_data[k][nwr[k]] = int'(wdata[k]);
               wr_sel[k][nwr[k]]  = int'(selv[k]);
               wr_edge[k][nwr[k]] = edge_n;
            end
            nwr[k]++;
         end else if (selv[k] == 7'b0100000) begin
            npoll[k]++;
         end else if (selv[k] != 7'b0) begin
            nbad[k]++;
         end
         if (done[k]) begin
            ndone[k]++;
            done_edge[k] = edge_n;
            if (err[k]) nerr[k]++;
         end else if (err[k]) begin
            nerr_alone[k]++;
         end
      end
   endtask

   task automatic drive();
      if (stall_left > 0 && src_rd[0]) begin
         gnt = 1'b0;
         stall_left--;
      end else begin
         gnt = ($urandom_range(0, 99) < cur_pct);
      end
      vblank = ((edge_n - cur_e0 + 1) <= cur_vb) ? 1'b0 : 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (cur_abort && !aborted[k] && nreads[k] == 3) begin
            abort[k]   = 1'b1;
            aborted[k] = 1'b1;
         end else begin
            abort[k] = 1'b0;
         end
      end
   endtask

   task automatic xfer(input string tag, input int s, input int d, input int n, input int sl,
                       input int pct, input int vbw, input bit do_abort, input bit do_rst,
                       input bit chk_gap);
      int nb, expw, p, lat;
      bit fin;
      for (int k = 0; k < 2; k++) begin
         nwr[k] = 0; ndone[k] = 0; done_edge[k] = 0; nerr[k] = 0; nerr_alone[k] = 0;
         npoll[k] = 0; nstall[k] = 0; nbad[k] = 0; nunst[k] = 0; nreads[k] = 0;
         aborted[k] = 1'b0;
      end
      cur_pct = pct; cur_vb = vbw; cur_abort = do_abort;
      src_in = 16'(s); dst_in = 12'(d); len_in = 13'(n); sel_in = 3'(sl);
      gnt = 1'b1; start = 1'b1;
      tick();
      start  = 1'b0;
      cur_e0 = edge_n;
      drive();
      fin = 1'b0;
      for (int c = 0; c < 20000 && !fin; c++) begin
         if (vbw > 0 && (edge_n - cur_e0 + 1) == vbw) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("%s[%0d] vb_polls", tag, k), npoll[k], vbw);
               chk($sformatf("%s[%0d] vb_reads", tag, k), nreads[k], 0);
               chk($sformatf("%s[%0d] vb_writes", tag, k), nwr[k], 0);
            end
         end
         if (do_rst && (edge_n - cur_e0) == 20) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            for (int k = 0; k < 2; k++)
               chk($sformatf("%s[%0d] outs_zero", tag, k),
                   longint'({busy[k], done[k], err[k], src_rd[k], wen[k], selv[k],
                             src_addr[k], vaddr[k], wdata[k]}), 0);
            fin = 1'b1;
         end else begin
            fin = (ndone[0] > 0 && ndone[1] > 0) ||
                  (do_abort && aborted[0] && aborted[1] && !busy[0] && !busy[1]);
         end
         if (!fin) begin
            tick();
            drive();
         end
      end
      if (!fin) chk({tag, " timeout"}, 0, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         drive();
      end
      for (int k = 0; k < 2; k++) begin
         nb = (n == 0 || sl > 4) ? 0 : n;
         chk($sformatf("%s[%0d] busy_end", tag, k), busy[k], 0);
         if (do_rst) begin
            chk($sformatf("%s[%0d] done_cnt", tag, k), ndone[k], 0);
            continue;
         end
         if (do_abort) begin
            chk($sformatf("%s[%0d] wr_cnt", tag, k), nwr[k], 2);
            chk($sformatf("%s[%0d] done_cnt", tag, k), ndone[k], 0);
            chk($sformatf("%s[%0d] rd_cnt", tag, k), nreads[k], 3);
            chk($sformatf("%s[%0d] rd_end", tag, k), src_rd[k], 0);
            nb = 2;
         end
         expw = (do_abort) ? 2 : nb + ((CLR_K[k] != 0 && nb > 0) ? 1 : 0);
         if (!do_abort) chk($sformatf("%s[%0d] wr_cnt", tag, k), nwr[k], expw);
         for (int i = 0; i < nb && i < nwr[k]; i++) begin
            chk($sformatf("%s[%0d] addr%0d", tag, k, i), wr_addr[k][i], (d + i) % 4096);
            chk($sformatf("%s[%0d] data%0d", tag, k, i), wr_data[k][i], mem[16'(s + i)]);
            chk($sformatf("%s[%0d] sel%0d", tag, k, i), wr_sel[k][i], 1 << sl);
         end
         if (do_abort) continue;
         if (expw > nb && nwr[k] >= expw) begin
            chk($sformatf("%s[%0d] clr_sel", tag, k), wr_sel[k][nb], 7'b1000000);
            chk($sformatf("%s[%0d] clr_data", tag, k), wr_data[k][nb], 0);
            chk($sformatf("%s[%0d] clr_edge", tag, k), wr_edge[k][nb], done_edge[k] - 1);
         end
         if (chk_gap && k == 0)
            for (int i = 1; i < nb && i < nwr[k]; i++)
               chk($sformatf("%s[%0d] gap%0d", tag, k, i), wr_edge[k][i] - wr_edge[k][i-1], 3);
         p   = (nb > 0) ? vbw + (nb + BURST_K[k] - 1) / BURST_K[k] : 0;
         lat = p + 3 * nb + nstall[k] + (expw - nb) + 1;
         chk($sformatf("%s[%0d] done_cnt", tag, k), ndone[k], 1);
         chk($sformatf("%s[%0d] err_cnt", tag, k), nerr[k], (sl > 4) ? 1 : 0);
         chk($sformatf("%s[%0d] err_alone", tag, k), nerr_alone[k], 0);
         chk($sformatf("%s[%0d] latency", tag, k), done_edge[k] - cur_e0 + 1, lat);
         chk($sformatf("%s[%0d] polls", tag, k), npoll[k], p);
         chk($sformatf("%s[%0d] rd_cnt", tag, k), nreads[k], nb);
         chk($sformatf("%s[%0d] stray_sel", tag, k), nbad[k], 0);
         chk($sformatf("%s[%0d] stall_hold", tag, k), nunst[k], 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; gnt = 1'b1; vblank = 1'b1;
      abort[0] = 1'b0; abort[1] = 1'b0;
      src_in = '0; dst_in = '0; len_in = '0; sel_in = '0;
      cur_pct = 100; cur_vb = 0; cur_e0 = 0; cur_abort = 1'b0; stall_left = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h1000] = 8'hAA; mem[16'h1001] = 8'hBB;
      mem[16'h1002] = 8'hCC; mem[16'h1003] = 8'hDD;
      for (int i = 0; i < 3; i++) tick();
      for (int k = 0; k < 2; k++)
         chk($sformatf("reset[%0d] outs_zero", k),
             longint'({busy[k], done[k], err[k], src_rd[k], wen[k], selv[k],
                       src_addr[k], vaddr[k], wdata[k]}), 0);
      rst_n = 1'b1;
      tick();
      chk("idle busy", busy[0] | busy[1], 0);

      xfer("basic", 'h1000, 'h010, 4, 4, 100, 0, 0, 0, 1);
      chk("basic done14", done_edge[0] - cur_e0 + 1, 14);
      xfer("vblank", 'h2345, 'h100, 6, 1, 100, 100, 0, 0, 0);
      xfer("empty", 'h0050, 'h020, 0, 2, 100, 0, 0, 0, 0);
      chk("empty done1", done_edge[0] - cur_e0 + 1, 1);
      xfer("illegal", 'h0060, 'h030, 8, 6, 100, 0, 0, 0, 0);
      xfer("dstwrap", 'h3000, 'hFFE, 4, 0, 100, 0, 0, 0, 0);
      xfer("srcwrap", 'hFFFE, 'h200, 5, 3, 60, 0, 0, 0, 0);
      stall_left = 5;
      xfer("stall", 'h4000, 'h300, 3, 2, 100, 0, 0, 0, 0);
      chk("stall cnt5", longint'(nstall[0] >= 5), 1);
      xfer("irqclr", 'h5000, 'h400, 1, 2, 100, 0, 0, 0, 0);
      xfer("abort", 'h6000, 'h500, 8, 1, 80, 0, 1, 0, 0);
      xfer("rstmid", 'h7000, 'h600, 40, 0, 70, 0, 0, 1, 0);
      for (int r = 0; r < 10; r++)
         xfer($sformatf("rand%0d", r), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 4095)), int'($urandom_range(1, 70)),
              int'($urandom_range(0, 4)), 70, int'($urandom_range(0, 5)), 0, 0, 0);
      xfer("maxlen", int'($urandom_range(0, 65535)), int'($urandom_range(0, 4095)),
           4096, 3, 100, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vram_dma.md
# vram_dma

Copy engine that moves a block of bytes from CPU-side memory into GPU VRAM without per-byte CPU stores. It is the initiator for the GPU's VRAM port, driving address, write data, write enable and the region SELECT lines. It polls the GPU's in-vblank status through the same port and writes only while VRAM is writable. It sits in the `cpu_clk` domain between the memory arbiter and the GPU's VRAM interface.

## Interface
- `VRAM_AW`, 12: width of `vram_address_o`.
- `BURST`, 32: bytes written between vblank re-polls (power of two, ≥1).
- `CLEAR_IRQ`, 0: if 1, issue one clear-vblank-IRQ write after the last byte.
- `cpu_clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start_i` in 1: accepted only in IDLE; latches `src_i`, `dst_i`, `len_i`, `sel_i`.
- `abort_i` in 1: cancels an active transfer.
- `src_i` in 16: source base address.
- `dst_i` in VRAM_AW: VRAM destination base.
- `len_i` in 13: byte count, 0..4096.
- `sel_i` in 3: region; 0 pmf, 1 pmb, 2 ntbl, 3 obm, 4 txbl, 5-7 illegal.
- `busy_o` out 1: high from the cycle after start acceptance until the DONE/IDLE return.
- `done_o` out 1: one-cycle pulse on completion.
- `err_o` out 1: one-cycle pulse, together with `done_o`, for an illegal `sel_i`.
- `src_addr_o` out 16, `src_rd_o` out 1, `src_gnt_i` in 1, `src_data_i` in 8: source read port.
  - A read is accepted in a cycle where `src_rd_o && src_gnt_i`.
  - `src_data_i` is valid in the following cycle.
- `vram_address_o` out VRAM_AW, `data_o` out 8, `wen_o` out 1, `vram_rdata_i` in 8: VRAM port.
- `SELECT_pmf_o`, `SELECT_pmb_o`, `SELECT_ntbl_o`, `SELECT_obm_o`, `SELECT_txbl_o`, `SELECT_in_vblank_o`, `SELECT_clr_vblank_irq_o` out 1 each: one-hot or all-zero.

## Operation
- All outputs are registered. Reset value of every output is 0; the FSM enters IDLE.
- FSM states: IDLE, POLL, READ, WAIT, WRITE, CLR, DONE.
- IDLE:
  - On `start_i` with `len_i==0`: go to DONE, no source or VRAM traffic.
  - On `start_i` with `sel_i>4`: go to DONE with `err_o`.
  - Otherwise: go to POLL, and load remaining=`len_i` and burst counter=`BURST`.
- POLL: `SELECT_in_vblank_o`=1 and `wen_o`=0 every cycle. `vram_rdata_i[0]` is sampled at the end of each cycle:
  - 1: go to READ.
  - 0: stay in POLL.
- READ: `src_rd_o`=1 and `src_addr_o`=current source address; hold until `src_gnt_i`, then go to WAIT.
- WAIT: capture `src_data_i` into the data register; go to WRITE.
- WRITE: one cycle with `wen_o`=1, `data_o`=the byte, `vram_address_o`=current dst, and the region SELECT high. Then:
  - Increment src (wraps mod 2^16) and dst (wraps mod 2^VRAM_AW).
  - Decrement remaining and the burst counter.
  - remaining==0: go to CLR if `CLEAR_IRQ`, else DONE.
  - Burst counter==0: reload it and go to POLL.
  - Otherwise: go to READ.
- CLR: one cycle with `wen_o`=1, `SELECT_clr_vblank_irq_o`=1, `data_o`=0; then DONE.
- DONE: `done_o`=1 for one cycle; go to IDLE.
- `abort_i` in any non-IDLE state: next state is IDLE. No `wen_o` or `src_rd_o` is asserted from the following cycle on, and `done_o` does not pulse. If abort coincides with a WRITE cycle, that write still completes.
- `rst_n` low mid-transfer: all outputs 0 in the following cycle, state IDLE, no completion pulse.
- `start_i` while busy is ignored. Inputs are only sampled at acceptance.
- Region SELECT lines are 0 in every cycle where `wen_o`=0, except `SELECT_in_vblank_o` in POLL.

## Timing
- Start accepted at edge E0: POLL is active in the cycle after E0.
- Throughput with `src_gnt_i`=1 and vblank: 3 cycles per byte (READ, WAIT, WRITE), plus 1 POLL cycle per burst.
- `len`=N≤BURST, no stalls, `CLEAR_IRQ`=0: `done_o` is high 3N+2 cycles after E0's cycle.
- Each `src_gnt_i` stall cycle adds exactly one cycle. Address and `src_rd_o` hold stable while stalled.
- vblank ending mid-burst is not detected until the next POLL; with BURST=32 the worst-case overrun is 96 cycles.

## Test plan
- Basic copy:
  - Stimulus: src 0x1000 holds AA BB CC DD; `dst_i`=0x010, `sel_i`=4, `len_i`=4, vblank=1, gnt=1.
  - Response: 4 `wen_o` pulses 3 cycles apart; addresses 0x010-0x013; data AA-DD; only `SELECT_txbl_o` high during them; `done_o` 14 cycles after start; `busy_o` low after.
- Vblank wait:
  - Stimulus: `vram_rdata_i[0]`=0 for 100 cycles, then 1.
  - Response: `SELECT_in_vblank_o` high all 100 cycles, no `src_rd_o`/`wen_o`; copy proceeds afterwards.
- Empty and illegal:
  - Stimulus: `len_i`=0.
  - Response: `done_o` in the cycle after acceptance, no traffic.
  - Stimulus: `sel_i`=6, `len_i`=8.
  - Response: `done_o` and `err_o` pulse together, no traffic.
- Wrap and burst:
  - Stimulus: VRAM_AW=12, BURST=2, `dst_i`=0xFFE, `len_i`=4.
  - Response: addresses FFE, FFF, 000, 001; exactly 2 POLL cycles, one before byte 0 and one before byte 2.
- Stall/abort/reset:
  - Stimulus: gnt low for 5 cycles during a READ.
  - Response: `src_addr_o` stable, no `wen_o`.
  - Stimulus: `abort_i` during WAIT of byte 2.
  - Response: no further `wen_o`, no `done_o`.
  - Stimulus: `rst_n`=0 mid-transfer.
  - Response: all outputs 0 next cycle.
- IRQ clear:
  - Stimulus: `CLEAR_IRQ`=1, `len_i`=1.
  - Response: the data write is followed by one `wen_o` cycle with only `SELECT_clr_vblank_irq_o` high, then `done_o`.
